qpsk_frame_gen: RTL and testbench
=================================

# qpsk_frame_gen

Baseband symbol source for the QPSK modulation path. It runs in the 120 MHz modulator clock domain and derives the symbol rate from an internal divider, so no separate low-rate PLL output is needed. It emits framed 2-bit symbols: a fixed preamble, then a PRBS-15 payload (optionally differentially encoded), then an idle gap. Its `sym_data` output feeds the QPSK modulator's base-data input directly.

## Interface
- `SYM_DIV`, 1200: clk cycles per symbol (120 MHz / 1200 = 100 kHz); legal range ≥ 2.
- `PREAMBLE_LEN`, 16: preamble symbols per frame; legal range ≥ 1.
- `PAYLOAD_LEN`, 240: payload symbols per frame; legal range ≥ 1.
- `GAP_LEN`, 8: idle symbol periods after each frame; legal range ≥ 1.
- `DIFF_EN`, 0: 1 = differential encoding of the payload.
- `clk`  in  1  120 MHz modulator clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  frame generation enable.
- `sym_data`  out  2  current symbol; held constant between ticks.
- `sym_valid`  out  1  one-cycle pulse each time a new symbol is presented.
- `frame_start`  out  1  pulse coincident with the first preamble `sym_valid`.
- `frame_end`  out  1  pulse coincident with the last payload `sym_valid`.
- `busy`  out  1  high in PREAMBLE and PAYLOAD.

## Operation
- **Reset:** all outputs reset to 0. Internal state on reset: FSM = IDLE, divider = 0, LFSR = 15'h7FFF, differential accumulator = 0.
- **States:** IDLE, PREAMBLE, PAYLOAD, GAP.
- **IDLE:** divider is held at 0. `en` = 1 moves the FSM to PREAMBLE.
- **Divider:** free-runs 0..SYM_DIV-1 in every state except IDLE. A tick occurs when divider = SYM_DIV-1, after which the divider wraps to 0.
- **On each tick:**
  - `sym_data` and the pulse outputs are registered.
  - The symbol counter advances.
  - State changes happen only on ticks.
- **PREAMBLE:** emits 2'b00, 2'b11, 2'b00, … (starting with 00) for PREAMBLE_LEN symbols, then goes to PAYLOAD.
- **PAYLOAD:** emits PAYLOAD_LEN symbols, then goes to GAP.
  - Each symbol steps the LFSR twice. The first new bit is dibit[1]; the second is dibit[0].
  - LFSR step: nb = l[14]^l[13]; l ← {l[13:0], nb}; emitted bit = nb.
  - The LFSR is reseeded to 7FFF at frame start.
- **DIFF_EN = 1 (payload only):**
  - sym_data = (acc + dibit) mod 4, and acc ← sym_data.
  - acc is cleared at frame start.
  - Preamble symbols are never differentially encoded.
- **GAP:** lasts GAP_LEN tick periods. During the gap, `sym_data` = 00 and `sym_valid` = 0. At the final gap tick:
  - `en` = 1 → PREAMBLE (new frame).
  - `en` = 0 → IDLE.
- **`en` deasserted mid-frame:** ignored. The frame completes, including the gap.
- **`rst_n` asserted mid-operation:** all state clears immediately. The next frame starts fresh, with the preamble and a reseeded PRBS.

## Timing
- **Start-up latency:** if `en` is sampled high in IDLE at edge t, the divider is 0 at cycle t+1. The first `sym_valid` (with `frame_start`) is high in cycle t+SYM_DIV+1.
- **Symbol spacing:** `sym_valid` pulses are exactly SYM_DIV cycles apart during PREAMBLE and PAYLOAD, including across the PREAMBLE→PAYLOAD boundary.
- **Frame period** (with `en` held high): (PREAMBLE_LEN + PAYLOAD_LEN + GAP_LEN) × SYM_DIV cycles.
- **Pulse coincidence:** `frame_start` and `frame_end` are each one cycle wide and coincide with their `sym_valid` pulses.
- **`busy`:** rises with `frame_start` and falls in the cycle after the tick that enters GAP.
- **`sym_data` hold:** after the last payload symbol, `sym_data` keeps that value until the first gap tick, then becomes 00.

## Structure
- **Package `qpsk_pkg`:** FSM state encoding, PRBS-15 seed (15'h7FFF), tap positions (14, 13), preamble dibits (2'b00, 2'b11).
- **Sub-module `prbs15_gen`:** inputs `clk`, `rst_n`, `reseed`, `step`; outputs the emitted bit and the state. The top block steps it twice per payload symbol, in two consecutive cycles before the tick.
- **Counters:**
  - Divider width: $clog2(SYM_DIV).
  - Symbol counter width: $clog2 of the maximum of the three lengths.

## Test plan
- **Reset/idle:** `rst_n` = 0 then 1, `en` = 0 for 10,000 cycles → all outputs 0 and no `sym_valid`.
- **Preamble:** SYM_DIV = 4, PREAMBLE_LEN = 4; `en` = 1 sampled at edge t → `sym_valid` at t+5, t+9, t+13, t+17 carrying 00, 11, 00, 11; `frame_start` at t+5 only.
- **PRBS payload:** DIFF_EN = 0 → payload dibits 1–7 = 00, dibit 8 = 10, dibit 9 = 00; `frame_end` on symbol PAYLOAD_LEN; the next frame repeats the identical payload.
- **Differential payload:** DIFF_EN = 1 → (sym[n] − sym[n−1]) mod 4, with sym[0]'s predecessor = 0, matches the DIFF_EN = 0 dibit stream from a reference model; the preamble is unchanged.
- **Enable drop:** `en` dropped mid-payload → frame completes, `frame_end` fires, GAP_LEN×SYM_DIV idle cycles follow, FSM goes to IDLE, no further `sym_valid`. With `en` held high → a new `frame_start` exactly one frame period after the previous one.
- **Reset mid-frame:** `rst_n` pulsed mid-payload → outputs 0 within the reset cycle. After release with `en` = 1 → a full preamble, then payload dibits beginning 00 ×7, 10.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK framed symbol source.
// Holds the FSM encoding, PRBS-15 seed and taps, and the preamble dibits.
package qpsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    localparam logic [14:0] PRBS_SEED  = 15'h7FFF;
    localparam int          PRBS_TAP_A = 14;
    localparam int          PRBS_TAP_B = 13;

    localparam logic [1:0] PRE_SYM_EVEN = 2'b00;
    localparam logic [1:0] PRE_SYM_ODD  = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/prbs15_gen.sv
// PRBS-15 (x^15 + x^14 + 1) generator; prbs_bit is the bit the next step shifts in.
// One step per cycle when step is high; reseed wins over step; no backpressure.
module prbs15_gen
    import qpsk_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reseed,
    input  logic        step,
    output logic        prbs_bit,
    output logic [14:0] lfsr_state
);

    assign prbs_bit = lfsr_state[PRBS_TAP_A] ^ lfsr_state[PRBS_TAP_B];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_state <= PRBS_SEED;
        end else if (reseed) begin
            lfsr_state <= PRBS_SEED;
        end else if (step) begin
            lfsr_state <= {lfsr_state[13:0], prbs_bit};
        end
    end

endmodule

// File: rtl/qpsk_frame_gen.sv
// Framed QPSK dibit source: preamble, PRBS-15 payload (optionally differential), idle gap.
// New symbol registered every SYM_DIV cycles; free-running source with no backpressure.
module qpsk_frame_gen
    import qpsk_pkg::*;
#(
    parameter int SYM_DIV      = 1200,
    parameter int PREAMBLE_LEN = 16,
    parameter int PAYLOAD_LEN  = 240,
    parameter int GAP_LEN      = 8,
    parameter bit DIFF_EN      = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [1:0] sym_data,
    output logic       sym_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       busy
);

    localparam int DIV_W   = $clog2(SYM_DIV);
    localparam int LEN_MAX = max3(PREAMBLE_LEN, PAYLOAD_LEN, GAP_LEN);
    localparam int CNT_W   = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HI   = DIV_W'(SYM_DIV - 2);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       acc_q, acc_d;
    logic [1:0]       sym_data_d;
    logic             sym_valid_d, frame_start_d, frame_end_d, busy_d;

    logic             tick;
    logic             prbs_bit;
    logic [14:0]      lfsr_state;
    logic [1:0]       dibit, payload_sym;

    assign tick = (state_q != ST_IDLE) && (div_q == DIV_LAST);

    // Steps land on the edges ending divider counts SYM_DIV-2 and SYM_DIV-1,
    // so at the tick the high bit sits in lfsr_state[0] and the low bit is prbs_bit.
    prbs15_gen u_prbs (
        .clk        (clk),
        .rst_n      (rst_n),
        .reseed     (state_q == ST_PREAMBLE),
        .step       ((state_q == ST_PAYLOAD) && (div_q == DIV_HI || div_q == DIV_LAST)),
        .prbs_bit   (prbs_bit),
        .lfsr_state (lfsr_state)
    );

    assign dibit       = {lfsr_state[0], prbs_bit};
    assign payload_sym = DIFF_EN ? (acc_q + dibit) : dibit;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        sym_data_d    = sym_data;
        sym_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        busy_d        = busy;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                acc_d = '0;
                if (en) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                acc_d = '0;
                if (tick) begin
                    sym_data_d    = cnt_q[0] ? PRE_SYM_ODD : PRE_SYM_EVEN;
                    sym_valid_d   = 1'b1;
                    frame_start_d = (cnt_q == '0);
                    busy_d        = 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (tick) begin
                    sym_data_d  = payload_sym;
                    acc_d       = payload_sym;
                    sym_valid_d = 1'b1;
                    if (cnt_q == PAY_LAST) begin
                        frame_end_d = 1'b1;
                        busy_d      = 1'b0;
                        cnt_d       = '0;
                        state_d     = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    sym_data_d = 2'b00;
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = en ? ST_PREAMBLE : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            sym_data    <= '0;
            sym_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= (state_q == ST_IDLE || tick) ? '0 : div_q + DIV_W'(1);
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sym_data    <= sym_data_d;
            sym_valid   <= sym_valid_d;
            frame_start <= frame_start_d;
            frame_end   <= frame_end_d;
            busy        <= busy_d;
        end
    end

    // An all-zero LFSR would lock up and emit a constant payload forever.
    lfsr_not_locked: assert property (@(posedge clk) disable iff (!rst_n) lfsr_state != '0);

endmodule

// File: tb/tb_qpsk_frame_gen.sv
// Bench for qpsk_frame_gen: plain and differential instances driven in lockstep,
// symbol scoreboard plus timing tables and reset/enable corner sequences.
module tb_qpsk_frame_gen;

    localparam int SD    = 4;
    localparam int PL    = 4;
    localparam int PY    = 12;
    localparam int GL    = 3;
    localparam int FRAME = (PL + PY + GL) * SD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    logic [1:0] s0, s1;
    logic       v0, fs0, fe0, b0;
    logic       v1, fs1, fe1, b1;

    always #5 clk = ~clk;

    qpsk_frame_gen #(.SYM_DIV(SD), .PREAMBLE_LEN(PL), .PAYLOAD_LEN(PY), .GAP_LEN(GL), .DIFF_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .sym_data(s0), .sym_valid(v0), .frame_start(fs0), .frame_end(fe0), .busy(b0)
    );

    qpsk_frame_gen #(.SYM_DIV(SD), .PREAMBLE_LEN(PL), .PAYLOAD_LEN(PY), .GAP_LEN(GL), .DIFF_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .sym_data(s1), .sym_valid(v1), .frame_start(fs1), .frame_end(fe1), .busy(b1)
    );

    typedef struct packed {
        logic [1:0] sym;
        logic       fs;
        logic       fe;
    } sb_t;

    typedef struct {
        int         off;
        logic       v;
        logic [1:0] d;
        logic       fs;
        logic       bz;
    } pre_vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         stray = 0;
    int         vcnt = 0;
    int         fe_cnt = 0;
    int         fe_edge = 0;
    sb_t        exp0[$];
    sb_t        exp1[$];
    logic [1:0] cap0[$];
    int         fs_edges[$];
    logic [1:0] last_pay;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: preamble, PRBS-15 payload from seed 7FFF, and its differential form.
    task automatic push_frame();
        logic [14:0] l;
        logic [1:0]  d, acc;
        l   = 15'h7FFF;
        acc = 2'b00;
        for (int i = 0; i < PL; i++) begin
            exp0.push_back('{sym: (i % 2 == 1) ? 2'b11 : 2'b00, fs: (i == 0), fe: 1'b0});
            exp1.push_back('{sym: (i % 2 == 1) ? 2'b11 : 2'b00, fs: (i == 0), fe: 1'b0});
        end
        for (int i = 0; i < PY; i++) begin
            d[1] = l[14] ^ l[13];
            l    = {l[13:0], d[1]};
            d[0] = l[14] ^ l[13];
            l    = {l[13:0], d[0]};
            acc  = acc + d;
            exp0.push_back('{sym: d,   fs: 1'b0, fe: (i == PY - 1)});
            exp1.push_back('{sym: acc, fs: 1'b0, fe: (i == PY - 1)});
            last_pay = d;
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            if ((!v0 && (fs0 || fe0)) || (!v1 && (fs1 || fe1)) || (v0 !== v1)) stray++;
            if (v0) begin
                vcnt++;
                cap0.push_back(s0);
                if (fs0) fs_edges.push_back(cyc);
                if (fe0) begin
                    fe_cnt++;
                    fe_edge = cyc;
                end
                if (exp0.size() == 0) begin
                    stray++;
                end else begin
                    e = exp0.pop_front();
                    check("sb0_sym", s0, e.sym);
                    check("sb0_flags", {fs0, fe0}, {e.fs, e.fe});
                end
            end
            if (v1) begin
                if (exp1.size() == 0) begin
                    stray++;
                end else begin
                    e = exp1.pop_front();
                    check("sb1_sym", s1, e.sym);
                    check("sb1_flags", {fs1, fe1}, {e.fs, e.fe});
                end
            end
        end
    end

    logic [1:0] pay_ref [9];
    pre_vec_t   pre_tab [9];

    task automatic check_prefix(input string tag);
        for (int i = 0; i < 9; i++)
            check($sformatf("%s_pay%0d", tag, i + 1), cap0[PL + i], pay_ref[i]);
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c - 1) @(negedge clk);
    endtask

    initial begin
        int t, guard, idle_bad, base, vmark, fe_prev;

        pay_ref = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
        pre_tab[0] = '{ 1, 1'b0, 2'b00, 1'b0, 1'b0};
        pre_tab[1] = '{ 4, 1'b0, 2'b00, 1'b0, 1'b0};
        pre_tab[2] = '{ 5, 1'b1, 2'b00, 1'b1, 1'b1};
        pre_tab[3] = '{ 6, 1'b0, 2'b00, 1'b0, 1'b1};
        pre_tab[4] = '{ 9, 1'b1, 2'b11, 1'b0, 1'b1};
        pre_tab[5] = '{12, 1'b0, 2'b11, 1'b0, 1'b1};
        pre_tab[6] = '{13, 1'b1, 2'b00, 1'b0, 1'b1};
        pre_tab[7] = '{17, 1'b1, 2'b11, 1'b0, 1'b1};
        pre_tab[8] = '{21, 1'b1, 2'b00, 1'b0, 1'b1};

        // Reset and long idle with en low
        repeat (3) @(negedge clk);
        check("reset_outputs", {s0, v0, fs0, fe0, b0, s1, v1, fs1, fe1, b1}, 0);
        rst_n = 1'b1;
        idle_bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if ({s0, v0, fs0, fe0, b0, s1, v1, fs1, fe1, b1} != 0) idle_bad++;
        end
        check("idle_quiet", idle_bad, 0);

        // Three frames back to back; preamble timing from the table
        push_frame();
        push_frame();
        push_frame();
        en = 1'b1;
        t  = cyc + 1;
        for (int i = 0; i < 9; i++) begin
            at_cycle(t + pre_tab[i].off);
            check($sformatf("pre_t%0d", pre_tab[i].off), {v0, s0, fs0, b0},
                  {pre_tab[i].v, pre_tab[i].d, pre_tab[i].fs, pre_tab[i].bz});
        end

        guard = 0;
        while (fs_edges.size() < 3 && guard < 5 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        check("wait_frame3", 32'(fs_edges.size() >= 3), 1);
        check("frame_period_1", fs_edges[1] - fs_edges[0], FRAME);
        check("frame_period_2", fs_edges[2] - fs_edges[1], FRAME);
        check_prefix("prbs");

        // Drop en mid-payload of frame 3: frame must still complete
        guard = 0;
        while (cap0.size() < 2 * (PL + PY) + PL + 3 && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        en = 1'b0;
        guard = 0;
        while (fe_cnt < 3 && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        check("frame3_end_seen", fe_cnt, 3);
        vmark = vcnt;
        at_cycle(fe_edge + SD);
        check("gap_hold_last", s0, last_pay);
        at_cycle(fe_edge + SD + 1);
        check("gap_data_zero", s0, 2'b00);
        check("gap_busy_low", b0, 1'b0);
        at_cycle(fe_edge + GL * SD + 200);
        check("no_valid_after_drop", vcnt, vmark);
        check("sb_drained", exp0.size() + exp1.size(), 0);

        // Re-enable from IDLE: start-up latency, then reset mid-payload
        base = cap0.size();
        push_frame();
        en = 1'b1;
        t  = cyc + 1;
        guard = 0;
        while (fs_edges.size() < 4 && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        check("restart_latency", fs_edges[$], t + SD);
        guard = 0;
        while (cap0.size() < base + PL + 5 && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", {s0, v0, fs0, fe0, b0, s1, v1, fs1, fe1, b1}, 0);
        exp0.delete();
        exp1.delete();
        cap0.delete();
        repeat (3) @(negedge clk);
        push_frame();
        fe_prev = fe_cnt;
        rst_n = 1'b1;
        t = cyc + 1;
        guard = 0;
        while (fe_cnt == fe_prev && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        en = 1'b0;
        check("post_rst_frame_end", fe_cnt, fe_prev + 1);
        check("post_rst_latency", fs_edges[$], t + SD);
        check("post_rst_len", cap0.size(), PL + PY);
        check("post_rst_preamble", {cap0[0], cap0[1], cap0[2], cap0[3]}, 8'b00_11_00_11);
        check_prefix("rst");
        repeat (3 * FRAME) @(negedge clk);
        check("final_sb_drained", exp0.size() + exp1.size(), 0);
        check("stray_events", stray, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
